// File: rtl/hex_display_pkg.sv
// Shared types and constants for the five-digit decimal display controller.
// The add3 helper is the per-cycle correction step of the shift-add-3 conversion.
package hex_display_pkg;

    localparam int NUM_DIGITS = 5;
    localparam int VALUE_W    = 16;
    localparam int BCD_W      = NUM_DIGITS * 4;
    localparam int CNT_W      = 4;

    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    // Any nibble of 5 or more would overflow past 9 after the next shift, so bump it by 3 first
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5)
                res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_seg7.sv
// Hex digit to active-low seven-segment decoder (segment order gfedcba).
module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Converts a 16-bit binary value to five decimal digits with an iterative shift-add-3
// engine and drives six seven-segment displays; the display only changes at LOAD.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        valid,
    output logic        ready,
    input  logic        enable,
    output logic        done,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    state_t                          state;
    logic [VALUE_W-1:0]              bin;
    logic [BCD_W-1:0]                bcd;
    logic [BCD_W-1:0]                bcd_adj;
    logic [CNT_W-1:0]                count;
    logic [NUM_DIGITS-1:0][3:0]      digits;
    logic [NUM_DIGITS-1:0][6:0]      seg_raw;
    logic [NUM_DIGITS-1:0][6:0]      hex;
    logic [NUM_DIGITS-1:0]           lead_zero;
    logic                            zero_above;

    assign ready   = (state == IDLE);
    assign bcd_adj = add3(bcd);

    // The digit registers are the only thing the displays see, so partial BCD never leaks out
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            count  <= '0;
            digits <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        bin   <= value;
                        bcd   <= '0;
                        count <= '0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd   <= {bcd_adj[BCD_W-2:0], bin[VALUE_W-1]};
                    bin   <= {bin[VALUE_W-2:0], 1'b0};
                    count <= count + 4'd1;
                    if (count == 4'd15)
                        state <= LOAD;
                end
                LOAD: begin
                    digits <= bcd;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit k is a leading zero when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above   = zero_above && (digits[k] == 4'd0);
            lead_zero[k] = zero_above && (BLANK_LZ != 0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7 u_seg7 (
            .digit (digits[g]),
            .seg   (seg_raw[g])
        );
        assign hex[g] = (!enable || lead_zero[g]) ? BLANK : seg_raw[g];
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = BLANK;

endmodule
